seg7_scan_mux: RTL
==================

# seg7_scan_mux

Time-multiplexed driver for a four-digit common-anode seven-segment display, placed directly downstream of the 16-bit hex-to-segment decoder. It takes the decoder's four 7-bit active-low segment patterns and per-digit suppression flags, latches them once per frame, and scans them onto one shared segment bus with one anode enabled at a time. A blanking interval at the start of every digit slot prevents ghosting.

## Interface
- `PRESCALE`, 50000: clock cycles per digit slot. Must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off. Must be at least 1.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `D_in` in 28: active-low segment patterns. Digit i occupies `D_in[7i+6:7i]`; digit 0 is the rightmost digit.
- `blank_in` in 4: bit i = 1 suppresses digit i (leading-zero suppression from the decoder).
- `dp_in` in 4: bit i = 1 lights the decimal point of digit i.
- `seg` out 7: active-low segments.
- `dp` out 1: active-low decimal point.
- `an` out 4: active-low anodes; at most one bit low in any cycle.
- `frame_done` out 1: one-cycle pulse when a new frame is latched.

## Operation
- FSM states:
  - IDLE: entered only by reset.
  - BLANK: all outputs off.
  - DRIVE: current digit shown.
- Internal registers:
  - `cnt`: slot counter, 0..`PRESCALE`-1, width `$clog2(PRESCALE)`.
  - `idx`: digit index, 2 bits, wraps 3→0.
  - Shadow registers for `D_in`, `blank_in` and `dp_in`.
- IDLE → BLANK on the first edge with `rst_n`=1. On that edge: latch the shadow registers, `cnt`=0, `idx`=0.
- BLANK → DRIVE when `cnt`=`BLANK_CYCLES`-1.
- DRIVE → BLANK when `cnt`=`PRESCALE`-1. On that edge: `cnt`=0 and `idx` increments. If `idx` was 3, it wraps to 0 and the shadow registers are re-latched from the inputs (frame boundary).
- `cnt` increments on every other edge.
- In BLANK, all outputs are off: `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- In DRIVE:
  - `an`=~(4'b0001<<`idx`).
  - `seg`=shadow pattern for digit `idx`.
  - `dp`=~shadow_dp[`idx`].
  - If shadow_blank[`idx`]=1, all outputs are off exactly as in BLANK; slot timing is unchanged.
- Input changes between frame boundaries have no visible effect until the next latch.
- `frame_done` asserts on every frame-boundary latch, but not on the IDLE→BLANK latch.

## Timing
- All outputs are registered, decoded from the next-state values, so outputs change on the same edge as the state transition.
- Reset values (on the edge where `rst_n`=0 is sampled): state=IDLE, `cnt`=0, `idx`=0, shadow patterns=7'h7F, shadow_blank=4'b1111, shadow_dp=0, `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_done`=0.
- Edge numbering: edge 1 is the first edge with `rst_n`=1.
  - Edge 1 latches the first frame; the display is dark for `BLANK_CYCLES` cycles.
  - Digit 0 anode goes low after edge 1+`BLANK_CYCLES`.
  - Slot period is exactly `PRESCALE` cycles; frame period is 4·`PRESCALE` cycles.
- `frame_done` is high for exactly the one cycle following the frame-boundary edge, i.e. the first BLANK cycle of digit 0's slot.
- Reset mid-operation, in any state or at any `cnt`: outputs go off on that same edge, shadow registers are cleared, and the scan restarts from IDLE.
- Slot boundaries have no overlap: the last DRIVE cycle of digit i is always followed by at least one all-off cycle before digit i+1 is enabled.

## Test plan
All scenarios use `PRESCALE`=8, `BLANK_CYCLES`=2.
- **Reset values:** hold `rst_n`=0 for 3 cycles with arbitrary inputs → `an`=1111, `seg`=7F, `dp`=1, `frame_done`=0 throughout; after release, 2 dark cycles, then `an`=1110.
- **Full scan:** `D_in` = {3:0x19, 2:0x30, 1:0x24, 0:0x79} (digits "4321"), `blank_in`=0 → over 32 cycles, `an` shows 1110, 1101, 1011, 0111, each for 6 cycles and each preceded by 2 cycles of 1111. `seg` shows 0x79, 0x24, 0x30, 0x19 during the matching DRIVE windows. `frame_done` pulses once every 32 cycles.
- **Suppression:** `blank_in`=1100 → during slots 2 and 3, `an`=1111 and `seg`=7F for all 8 cycles of each slot; slots 0 and 1 are unchanged; period is still 32.
- **Mid-frame update:** change `D_in` digit 0 from 0x79 to 0x40 during slot 1 → slot 0 of the current frame already showed 0x79; 0x40 first appears in slot 0 after the next `frame_done`.
- **Decimal point:** `dp_in`=0010 → `dp`=0 only during digit 1's DRIVE cycles; `dp`=1 at all other times, including BLANK cycles.
- **Reset mid-DRIVE:** assert `rst_n`=0 at `cnt`=5 of slot 2 → `an`=1111 on that edge; after release, scanning restarts at digit 0 with a 2-cycle dark lead-in and no `frame_done` for the restart latch.

Source files
------------

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// seg7_scan_mux : four-digit common-anode 7-seg scanner with per-slot blanking
// Revision      : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] D_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(PRESCALE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] c_slot_last  = CW'(PRESCALE - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [27:0]   r_d;
  logic [3:0]    r_blank;
  logic [3:0]    r_dpm;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_frame_done;

  logic [1:0]    w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [1:0]    w_idx_nx;
  logic          w_latch;
  logic          w_frame;
  logic [27:0]   w_d_nx;
  logic [3:0]    w_blank_nx;
  logic [3:0]    w_dpm_nx;
  logic          w_show;
  logic [6:0]    w_seg_sel;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_idx_nx   = r_idx;
    w_latch    = 1'b0;
    w_frame    = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nx = BLANK;
        w_cnt_nx   = '0;
        w_idx_nx   = 2'd0;
        w_latch    = 1'b1;
      end
      BLANK: begin
        if (r_cnt == c_blank_last) w_state_nx = DRIVE;
      end
      DRIVE: begin
        if (r_cnt == c_slot_last) begin
          w_state_nx = BLANK;
          w_cnt_nx   = '0;
          w_idx_nx   = r_idx + 2'd1;
          // Wrapping past digit 3 is the frame boundary
          if (r_idx == 2'd3) begin
            w_latch = 1'b1;
            w_frame = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
        w_idx_nx   = 2'd0;
      end
    endcase
  end

  // Outputs decode the next-state values so they switch on the transition edge
  always_comb begin
    w_d_nx     = w_latch ? D_in     : r_d;
    w_blank_nx = w_latch ? blank_in : r_blank;
    w_dpm_nx   = w_latch ? dp_in    : r_dpm;
    case (w_idx_nx)
      2'd0:    w_seg_sel = w_d_nx[6:0];
      2'd1:    w_seg_sel = w_d_nx[13:7];
      2'd2:    w_seg_sel = w_d_nx[20:14];
      default: w_seg_sel = w_d_nx[27:21];
    endcase
    w_show = (w_state_nx == DRIVE) && !w_blank_nx[w_idx_nx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_d          <= {4{7'h7F}};
      r_blank      <= 4'b1111;
      r_dpm        <= 4'b0000;
      r_an         <= 4'b1111;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_idx        <= w_idx_nx;
      r_d          <= w_d_nx;
      r_blank      <= w_blank_nx;
      r_dpm        <= w_dpm_nx;
      r_frame_done <= w_frame;
      if (w_show) begin
        r_an  <= ~(4'b0001 << w_idx_nx);
        r_seg <= w_seg_sel;
        r_dp  <= ~w_dpm_nx[w_idx_nx];
      end else begin
        r_an  <= 4'b1111;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
